// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and segment constants for the memory request arbiter.
// Address types, FSM state encoding and MIPS kseg0/kseg1 high-nibble values.
package mem_req_arbiter_pkg;

  typedef logic [31:0] vaddr_t;
  typedef logic [31:0] paddr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // kseg0 is cached, kseg1 is uncached; both map onto the low 512 MB.
  localparam logic [3:0] KSEG0_NIB_LO = 4'h8;
  localparam logic [3:0] KSEG0_NIB_HI = 4'h9;
  localparam logic [3:0] KSEG1_NIB_LO = 4'hA;
  localparam logic [3:0] KSEG1_NIB_HI = 4'hB;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and bus-side signals of the memory request arbiter.
// master = arbiter view, slave = the requesters plus the downstream bus.
interface mem_req_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import mem_req_arbiter_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  vaddr_t [NUM_REQ-1:0]     req_vaddr;
  logic [NUM_REQ-1:0]       req_is_write;
  logic [NUM_REQ-1:0][31:0] req_wdata;
  logic [NUM_REQ-1:0][3:0]  req_strobe;
  logic [NUM_REQ-1:0]       req_ready;
  logic [31:0]              resp_data;

  logic                     bus_valid;
  paddr_t                   bus_paddr;
  logic                     bus_is_write;
  logic [31:0]              bus_wdata;
  logic [3:0]               bus_strobe;
  logic                     bus_uncached;
  logic                     bus_ready;
  logic [31:0]              bus_rdata;

  modport master (
    input  req_valid, req_vaddr, req_is_write, req_wdata, req_strobe,
    input  bus_ready, bus_rdata,
    output req_ready, resp_data,
    output bus_valid, bus_paddr, bus_is_write, bus_wdata, bus_strobe, bus_uncached
  );

  modport slave (
    output req_valid, req_vaddr, req_is_write, req_wdata, req_strobe,
    output bus_ready, bus_rdata,
    input  req_ready, resp_data,
    input  bus_valid, bus_paddr, bus_is_write, bus_wdata, bus_strobe, bus_uncached
  );

endinterface

// File: rtl/mem_req_arbiter_kseg_xlate.sv
// Combinational kseg0/kseg1 virtual-to-physical translation.
// Segments 0x8/0xA fold to 0x0, 0x9/0xB fold to 0x1; kseg1 is flagged uncached.
module kseg_xlate
  import mem_req_arbiter_pkg::*;
(
  input  vaddr_t vaddr,
  output paddr_t paddr,
  output logic   uncached
);

  always_comb begin
    paddr = vaddr;
    case (vaddr[31:28])
      KSEG0_NIB_LO, KSEG1_NIB_LO: paddr[31:28] = 4'h0;
      KSEG0_NIB_HI, KSEG1_NIB_HI: paddr[31:28] = 4'h1;
      default:                    paddr[31:28] = vaddr[31:28];
    endcase
    uncached = (vaddr[31:29] == 3'b101);
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates NUM_REQ requesters onto one memory bus, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  arb_state_t         state_reg, state_next;
  idx_t               winner_reg;
  paddr_t             paddr_reg;
  logic               is_write_reg;
  logic [31:0]        wdata_reg;
  logic [3:0]         strobe_reg;
  logic               uncached_reg;
  logic               bus_valid_reg;
  logic [NUM_REQ-1:0] req_ready_reg;
  logic [31:0]        resp_data_reg;

  idx_t               cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] winner_onehot;
  logic               grant_any;
  idx_t               grant_idx;
  vaddr_t             sel_vaddr;
  paddr_t             sel_paddr;
  logic               sel_uncached;

  genvar gi;

`ifdef ARB_ROUND_ROBIN_EN
  idx_t rr_ptr_reg;

  // Candidate order starts just after the last winner.
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = idx_t'((32'(rr_ptr_reg) + 32'(gi) + 32'd1) % 32'(NUM_REQ));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= idx_t'(NUM_REQ - 1);
    end else if (state_reg == IDLE && grant_any) begin
      rr_ptr_reg <= grant_idx;
    end
  end
`else
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = idx_t'(gi);
  end
`endif

  // Walk candidates from last to first so the earliest valid one wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[cand_idx[i]]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[i];
      end
    end
  end

  assign sel_vaddr = bus.req_vaddr[grant_idx];

  kseg_xlate u_xlate (
    .vaddr    (sel_vaddr),
    .paddr    (sel_paddr),
    .uncached (sel_uncached)
  );

  for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign winner_onehot[gi] = (winner_reg == idx_t'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = BUSY;
      BUSY:    if (bus.bus_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Payload is frozen at grant; requester-side changes afterwards are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      winner_reg    <= '0;
      paddr_reg     <= '0;
      is_write_reg  <= 1'b0;
      wdata_reg     <= '0;
      strobe_reg    <= '0;
      uncached_reg  <= 1'b0;
      bus_valid_reg <= 1'b0;
      req_ready_reg <= '0;
      resp_data_reg <= '0;
    end else begin
      req_ready_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            winner_reg    <= grant_idx;
            paddr_reg     <= sel_paddr;
            is_write_reg  <= bus.req_is_write[grant_idx];
            wdata_reg     <= bus.req_wdata[grant_idx];
            strobe_reg    <= bus.req_strobe[grant_idx];
            uncached_reg  <= sel_uncached;
            bus_valid_reg <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.bus_ready) begin
            bus_valid_reg <= 1'b0;
            resp_data_reg <= bus.bus_rdata;
            req_ready_reg <= winner_onehot;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_valid    = bus_valid_reg;
  assign bus.bus_paddr    = paddr_reg;
  assign bus.bus_is_write = is_write_reg;
  assign bus.bus_wdata    = wdata_reg;
  assign bus.bus_strobe   = strobe_reg;
  assign bus.bus_uncached = uncached_reg;
  assign bus.req_ready    = req_ready_reg;
  assign bus.resp_data    = resp_data_reg;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized
// traffic checked against an address-range / priority reference model.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int NUM_REQ = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.NUM_REQ(NUM_REQ)) ifc();

  mem_req_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int vectors = 0;
  int miscompares = 0;
  int rr_last = NUM_REQ - 1;

  typedef struct {
    int                 waits;
    logic [31:0]        paddr;
    logic               is_write;
    logic [31:0]        wdata;
    logic [3:0]         strobe;
    logic               uncached;
    logic               changed;
    int                 early_ready;
    logic [NUM_REQ-1:0] ready;
    logic [31:0]        resp;
    logic [NUM_REQ-1:0] ready_after;
    logic               valid_after;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kseg0/kseg1 occupy 0x8000_0000..0xBFFF_FFFF and alias the low 512 MB.
  function automatic logic [31:0] model_paddr(input logic [31:0] va);
    if (va >= 32'h8000_0000 && va < 32'hC000_0000) return va % 32'h2000_0000;
    return va;
  endfunction

  function automatic logic model_uncached(input logic [31:0] va);
    return (va >= 32'hA000_0000 && va < 32'hC000_0000);
  endfunction

  function automatic int model_pick(input logic [NUM_REQ-1:0] v);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (rr_last + k) % NUM_REQ;
      if (v[c]) return c;
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    int r;
    int n;
    r = -1;
    n = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[k] === 1'b1) begin
        r = k;
        n++;
      end
    end
    return (n == 1) ? r : -1;
  endfunction

  task automatic clear_inputs();
    ifc.req_valid    = '0;
    ifc.req_vaddr    = '0;
    ifc.req_is_write = '0;
    ifc.req_wdata    = '0;
    ifc.req_strobe   = '0;
    ifc.bus_ready    = 1'b0;
    ifc.bus_rdata    = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rr_last = NUM_REQ - 1;
  endtask

  task automatic set_req(input int r, input logic [31:0] va, input logic wr,
                         input logic [31:0] wd, input logic [3:0] st);
    ifc.req_valid[r]    = 1'b1;
    ifc.req_vaddr[r]    = va;
    ifc.req_is_write[r] = wr;
    ifc.req_wdata[r]    = wd;
    ifc.req_strobe[r]   = st;
  endtask

  // Bus responder: waits for bus_valid, stalls, completes, observes the ready pulse.
  task automatic do_txn(input int stall, input logic [31:0] rdata, input bit drop,
                        input bit scramble, output obs_t o);
    o = '{default: 0};
    o.waits = -1;
    for (int w = 1; w <= 16; w++) begin
      tick();
      if (ifc.bus_valid === 1'b1) begin
        o.waits = w;
        break;
      end
    end
    if (o.waits < 0) return;
    o.paddr    = ifc.bus_paddr;
    o.is_write = ifc.bus_is_write;
    o.wdata    = ifc.bus_wdata;
    o.strobe   = ifc.bus_strobe;
    o.uncached = ifc.bus_uncached;
    for (int s = 0; s < stall; s++) begin
      if (scramble) begin
        for (int r = 0; r < NUM_REQ; r++) begin
          ifc.req_vaddr[r]    = $urandom();
          ifc.req_wdata[r]    = $urandom();
          ifc.req_strobe[r]   = 4'($urandom());
          ifc.req_is_write[r] = 1'($urandom());
        end
      end
      tick();
      if (ifc.bus_valid !== 1'b1 || ifc.bus_paddr !== o.paddr || ifc.bus_is_write !== o.is_write ||
          ifc.bus_wdata !== o.wdata || ifc.bus_strobe !== o.strobe || ifc.bus_uncached !== o.uncached)
        o.changed = 1'b1;
      if (ifc.req_ready !== '0) o.early_ready++;
    end
    ifc.bus_ready = 1'b1;
    ifc.bus_rdata = rdata;
    tick();
    ifc.bus_ready = 1'b0;
    ifc.bus_rdata = $urandom();
    o.ready = ifc.req_ready;
    o.resp  = ifc.resp_data;
    if (drop) ifc.req_valid = ifc.req_valid & ~ifc.req_ready;
    tick();
    o.ready_after = ifc.req_ready;
    o.valid_after = ifc.bus_valid;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    vectors++; if (ifc.bus_valid !== 1'b0) begin miscompares++; $display("FAIL reset bus_valid: got %b expected 0", ifc.bus_valid); end
    vectors++; if (ifc.req_ready !== '0) begin miscompares++; $display("FAIL reset req_ready: got %b expected 0", ifc.req_ready); end
    vectors++; if (ifc.resp_data !== 32'h0) begin miscompares++; $display("FAIL reset resp_data: got %h expected 0", ifc.resp_data); end
    vectors++;
    if ({ifc.bus_paddr, ifc.bus_wdata, ifc.bus_strobe, ifc.bus_is_write, ifc.bus_uncached} !== '0) begin
      miscompares++;
      $display("FAIL reset payload: got paddr=%h wdata=%h strobe=%b wr=%b unc=%b expected all 0",
               ifc.bus_paddr, ifc.bus_wdata, ifc.bus_strobe, ifc.bus_is_write, ifc.bus_uncached);
    end
    reset = 1'b0;
    rr_last = NUM_REQ - 1;
  endtask

  task automatic test_single_read();
    obs_t o;
    set_req(0, 32'hBFC0_0000, 1'b0, 32'h0, 4'hF);
    do_txn(1, 32'h1234_5678, 1'b1, 1'b0, o);
    rr_last = 0;
    vectors++; if (o.waits !== 1) begin miscompares++; $display("FAIL read latency: got %0d expected 1", o.waits); end
    vectors++; if (o.paddr !== 32'h1FC0_0000) begin miscompares++; $display("FAIL read paddr: got %h expected 1fc00000", o.paddr); end
    vectors++; if (o.uncached !== 1'b1) begin miscompares++; $display("FAIL read uncached: got %b expected 1", o.uncached); end
    vectors++; if (o.ready !== 2'b01) begin miscompares++; $display("FAIL read req_ready: got %b expected 01", o.ready); end
    vectors++; if (o.resp !== 32'h1234_5678) begin miscompares++; $display("FAIL read resp_data: got %h expected 12345678", o.resp); end
    vectors++; if (o.ready_after !== '0 || o.valid_after !== 1'b0) begin miscompares++; $display("FAIL read after: got ready=%b valid=%b expected 0/0", o.ready_after, o.valid_after); end
  endtask

  task automatic test_translation();
    logic [31:0] tbl [7];
    obs_t o;
    int r;
    tbl = '{32'h8000_1000, 32'hA000_1000, 32'h9000_0004, 32'h0040_0000,
            32'hBFFF_FFFC, 32'hC000_0000, 32'h7FFF_FFFC};
    for (int i = 0; i < 7; i++) begin
      r = i % NUM_REQ;
      set_req(r, tbl[i], 1'b0, 32'h0, 4'hF);
      do_txn(0, $urandom(), 1'b1, 1'b0, o);
      rr_last = r;
      vectors++; if (o.paddr !== model_paddr(tbl[i])) begin miscompares++; $display("FAIL xlate paddr va=%h: got %h expected %h", tbl[i], o.paddr, model_paddr(tbl[i])); end
      vectors++; if (o.uncached !== model_uncached(tbl[i])) begin miscompares++; $display("FAIL xlate uncached va=%h: got %b expected %b", tbl[i], o.uncached, model_uncached(tbl[i])); end
    end
  endtask

  task automatic test_write();
    obs_t o;
    set_req(1, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    do_txn(4, $urandom(), 1'b1, 1'b1, o);
    rr_last = 1;
    vectors++; if (o.paddr !== 32'h0000_0010) begin miscompares++; $display("FAIL write paddr: got %h expected 00000010", o.paddr); end
    vectors++; if (o.is_write !== 1'b1) begin miscompares++; $display("FAIL write is_write: got %b expected 1", o.is_write); end
    vectors++; if (o.wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL write wdata: got %h expected deadbeef", o.wdata); end
    vectors++; if (o.strobe !== 4'b0011) begin miscompares++; $display("FAIL write strobe: got %b expected 0011", o.strobe); end
    vectors++; if (o.changed !== 1'b0) begin miscompares++; $display("FAIL write latch: got bus change=%b expected 0", o.changed); end
    vectors++; if (o.ready !== 2'b10) begin miscompares++; $display("FAIL write req_ready: got %b expected 10", o.ready); end
  endtask

  task automatic test_contention();
    obs_t o;
    logic [31:0] va [NUM_REQ];
    int exp;
    apply_reset();
    va[0] = 32'h8000_0100;
    va[1] = 32'hA000_0200;
    set_req(0, va[0], 1'b0, 32'h0, 4'hF);
    set_req(1, va[1], 1'b1, 32'h5555_AAAA, 4'hC);
    for (int n = 0; n < 5; n++) begin
      if (n == 4) ifc.req_valid[0] = 1'b0;
      exp = model_pick(ifc.req_valid);
      do_txn(0, $urandom(), 1'b0, 1'b0, o);
      rr_last = exp;
      vectors++; if (oh_idx(o.ready) !== exp) begin miscompares++; $display("FAIL contention grant %0d: got %0d expected %0d", n, oh_idx(o.ready), exp); end
      vectors++; if (o.paddr !== model_paddr(va[exp])) begin miscompares++; $display("FAIL contention paddr %0d: got %h expected %h", n, o.paddr, model_paddr(va[exp])); end
      vectors++; if (o.waits !== 1) begin miscompares++; $display("FAIL contention period %0d: got wait %0d expected 1", n, o.waits); end
    end
    ifc.req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    obs_t o;
    set_req(0, 32'h0040_0000, 1'b0, 32'h0, 4'hF);
    tick();
    vectors++; if (ifc.bus_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid busy: got bus_valid %b expected 1", ifc.bus_valid); end
    reset = 1'b1;
    ifc.req_valid = '0;
    tick();
    reset = 1'b0;
    rr_last = NUM_REQ - 1;
    vectors++; if (ifc.bus_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid bus_valid: got %b expected 0", ifc.bus_valid); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (ifc.req_ready !== '0) begin miscompares++; $display("FAIL rstmid ready pulse: got %b expected 0", ifc.req_ready); end
      tick();
    end
    set_req(1, 32'h9000_0004, 1'b0, 32'h0, 4'hF);
    do_txn(1, 32'hCAFE_0001, 1'b1, 1'b0, o);
    rr_last = 1;
    vectors++; if (o.waits !== 1 || o.ready !== 2'b10) begin miscompares++; $display("FAIL rstmid regrant: got wait %0d ready %b expected 1 10", o.waits, o.ready); end
    vectors++; if (o.paddr !== 32'h1000_0004) begin miscompares++; $display("FAIL rstmid paddr: got %h expected 10000004", o.paddr); end
  endtask

  task automatic test_long_stall();
    obs_t o;
    set_req(0, 32'hA000_0040, 1'b1, 32'h0BAD_F00D, 4'b1000);
    do_txn(20, 32'h7777_0000, 1'b1, 1'b0, o);
    rr_last = 0;
    vectors++; if (o.changed !== 1'b0) begin miscompares++; $display("FAIL stall stable: got change %b expected 0", o.changed); end
    vectors++; if (o.early_ready !== 0) begin miscompares++; $display("FAIL stall early ready: got %0d expected 0", o.early_ready); end
    vectors++; if (o.ready !== 2'b01 || o.ready_after !== '0) begin miscompares++; $display("FAIL stall pulse: got %b then %b expected 01 then 00", o.ready, o.ready_after); end
    vectors++; if (o.resp !== 32'h7777_0000) begin miscompares++; $display("FAIL stall resp_data: got %h expected 77770000", o.resp); end
  endtask

  task automatic test_random();
    logic [31:0] va [NUM_REQ];
    logic        wr [NUM_REQ];
    logic [31:0] wd [NUM_REQ];
    logic [3:0]  st [NUM_REQ];
    logic [3:0]  nib [9];
    logic [31:0] rd;
    obs_t o;
    int exp;
    nib = '{4'h0, 4'h1, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!ifc.req_valid[r] && ($urandom_range(0, 1) == 1 || (it % 7) == 0)) begin
          va[r] = {nib[$urandom_range(0, 8)], 28'($urandom())};
          wr[r] = 1'($urandom());
          wd[r] = $urandom();
          st[r] = 4'($urandom());
          set_req(r, va[r], wr[r], wd[r], st[r]);
        end
      end
      if (ifc.req_valid == '0) begin
        va[0] = $urandom();
        wr[0] = 1'b0;
        wd[0] = $urandom();
        st[0] = 4'hF;
        set_req(0, va[0], wr[0], wd[0], st[0]);
      end
      exp = model_pick(ifc.req_valid);
      rd = $urandom();
      do_txn($urandom_range(0, 3), rd, 1'b1, 1'b0, o);
      rr_last = exp;
      vectors++; if (oh_idx(o.ready) !== exp) begin miscompares++; $display("FAIL rand %0d grant: got %0d expected %0d", it, oh_idx(o.ready), exp); end
      if (exp >= 0) begin
        vectors++;
        if (o.paddr !== model_paddr(va[exp]) || o.uncached !== model_uncached(va[exp])) begin
          miscompares++;
          $display("FAIL rand %0d xlate va=%h: got %h/%b expected %h/%b", it, va[exp], o.paddr, o.uncached,
                   model_paddr(va[exp]), model_uncached(va[exp]));
        end
        vectors++;
        if (o.is_write !== wr[exp] || o.wdata !== wd[exp] || o.strobe !== st[exp]) begin
          miscompares++;
          $display("FAIL rand %0d payload: got %b/%h/%b expected %b/%h/%b", it, o.is_write, o.wdata, o.strobe,
                   wr[exp], wd[exp], st[exp]);
        end
      end
      vectors++; if (o.resp !== rd) begin miscompares++; $display("FAIL rand %0d resp_data: got %h expected %h", it, o.resp, rd); end
      vectors++; if (o.changed !== 1'b0 || o.waits !== 1) begin miscompares++; $display("FAIL rand %0d timing: got change %b wait %0d expected 0 1", it, o.changed, o.waits); end
    end
    ifc.req_valid = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_translation();
    test_write();
    test_contention();
    test_reset_mid();
    test_long_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
